// File: rtl/cdc_handshake_src.sv
// -----------------------------------------------------------------------------
// cdc_handshake_src
//
// Source side of a 4-phase req/ack clock-domain-crossing handshake. A word
// offered on src_valid/src_data is captured when src_ready is high, held on
// data_out, and announced to the destination domain by raising req_out. The
// asynchronous acknowledge is brought into this domain through a SYNC_STAGES
// flop chain; only the final flop (ack_s) feeds any logic.
//
// Handshake sequence:
//   IDLE        -- accept word: data_out <= src_data, req_out <= 1
//   WAIT_ACK_HI -- ack_s seen high: req_out <= 0, done pulses for one cycle
//   WAIT_ACK_LO -- ack_s seen low: back to IDLE, ready for the next word
//
// Parameters:
//   DATA_W      width of the transferred word
//   SYNC_STAGES flops in the ack synchronizer chain (legal range 2..4)
//
// Ports:
//   clk         source-domain clock, all flops on its rising edge
//   async_rst   asynchronous active-high reset
//   scan_enable DFT hook, no functional effect
//   src_valid   source offers src_data this cycle
//   src_data    word to transfer
//   src_ready   word will be accepted this cycle if src_valid is high
//   req_out     4-phase request to destination domain (flop output)
//   data_out    held word to destination domain (flop outputs)
//   ack_in      asynchronous acknowledge from destination domain
//   busy        high whenever a handshake is in progress (state != IDLE)
//   done        one-cycle pulse when the destination acknowledges a word
// -----------------------------------------------------------------------------
module cdc_handshake_src #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 3
) (
  input  logic              clk,
  input  logic              async_rst,
  input  logic              scan_enable,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   ack_s;
  logic                   accept;
  logic                   req_next;
  logic                   done_next;

  // scan_enable is a DFT hook only; it is deliberately left without function.
  logic unused_scan_enable;
  assign unused_scan_enable = scan_enable;

  // ---------------------------------------------------------------------------
  // Ack synchronizer. Only the last stage is observed; the earlier stages exist
  // purely to let metastability resolve.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_s  = sync_reg[SYNC_STAGES-1];
  assign accept = src_valid && src_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:        if (accept) state_next = WAIT_ACK_HI;
      WAIT_ACK_HI: if (ack_s)  state_next = WAIT_ACK_LO;
      WAIT_ACK_LO: if (!ack_s) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic. src_ready and busy depend only on flops; req_next and
  // done_next feed the registered req_out/done so both leave the block from
  // flops with no glitches towards the other domain.
  // ---------------------------------------------------------------------------
  always_comb begin
    src_ready = 1'b0;
    busy      = 1'b1;
    req_next  = 1'b0;
    done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        busy      = 1'b0;
        // A stale ack still visible from a previous (possibly reset-aborted)
        // handshake must drain before a new request may be raised.
        src_ready = !ack_s;
        req_next  = src_valid && !ack_s;
      end
      WAIT_ACK_HI: begin
        req_next  = !ack_s;
        done_next = ack_s;
      end
      WAIT_ACK_LO: begin
        // Ack bouncing here only stretches this state; request stays low.
        req_next  = 1'b0;
      end
      default: begin
        busy      = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output flops. data_out only loads on accept so it stays stable for the
  // destination through the whole handshake and afterwards.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      req_out  <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      req_out <= req_next;
      done    <= done_next;
      if (accept) begin
        data_out <= src_data;
      end
    end
  end

endmodule

// File: tb/tb_cdc_handshake_src.sv
// -----------------------------------------------------------------------------
// tb_cdc_handshake_src
//
// Directed bench for cdc_handshake_src (DATA_W = 32, SYNC_STAGES = 3).
// Inputs are driven 1 time unit after each rising clock edge and outputs are
// sampled at that same point, so everything observed reflects the last edge.
// A three-flop model of the ack synchronizer is kept alongside the DUT to know
// what ack_s was at each edge without looking inside the design.
// -----------------------------------------------------------------------------
module tb_cdc_handshake_src;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          async_rst = 1'b0;
  logic          scan_enable = 1'b0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic          req_out;
  logic [DW-1:0] data_out;
  logic          ack_in = 1'b0;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  // model of the ack synchronizer
  logic [2:0] sync_m = '0;
  logic       ack_s_pre = 1'b0;

  // scratch state for the scenarios
  int   done_cnt;
  int   bad_hold;
  int   sent;
  int   rcvd;
  int   viol;
  int   resp_wait;
  logic acc;
  logic req_prev;

  cdc_handshake_src #(
    .DATA_W      (DW),
    .SYNC_STAGES (3)
  ) dut (
    .clk         (clk),
    .async_rst   (async_rst),
    .scan_enable (scan_enable),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .req_out     (req_out),
    .data_out    (data_out),
    .ack_in      (ack_in),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; the sync model shifts exactly as the DUT chain does.
  task automatic tick();
    ack_s_pre = sync_m[2];
    if (async_rst) sync_m = '0;
    else           sync_m = {sync_m[1:0], ack_in};
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #1 async_rst = 1'b1;
    #1;
    check("rst_req_out",  req_out,  1'b0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_done",     done,     1'b0);
    check("rst_busy",     busy,     1'b0);
    @(posedge clk);
    #1;
    tick();
    async_rst = 1'b0;
    tick();
    check("rst_release_ready", src_ready, 1'b1);

    // ---------------- basic transfer ----------------
    src_valid = 1'b1;
    src_data  = 32'hDEADBEEF;
    tick();                                    // edge N: accept
    src_valid = 1'b0;
    src_data  = 32'h0;
    check("basic_req_n",      req_out,   1'b1);
    check("basic_data_n",     data_out,  32'hDEADBEEF);
    check("basic_busy_n",     busy,      1'b1);
    check("basic_ready_n",    src_ready, 1'b0);
    tick();                                    // N+1
    tick();                                    // N+2
    ack_in = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      tick();
      check("basic_no_early_done", done,    1'b0);
      check("basic_req_held",      req_out, 1'b1);
    end
    tick();                                    // N+6
    check("basic_done_n6",    done,     1'b1);
    check("basic_req_fall",   req_out,  1'b0);
    check("basic_data_n6",    data_out, 32'hDEADBEEF);
    $display("xfer basic data=0x%08h", data_out);
    ack_in = 1'b0;
    tick();                                    // N+7
    check("basic_done_1cyc",  done,     1'b0);
    check("basic_busy_n7",    busy,     1'b1);
    tick();                                    // N+8
    tick();                                    // N+9
    check("compl_busy_n9",    busy,      1'b1);
    check("compl_ready_n9",   src_ready, 1'b0);
    tick();                                    // N+10: back to IDLE
    check("compl_idle_n10",   busy,      1'b0);
    check("compl_ready_n10",  src_ready, 1'b1);
    check("compl_data_hold",  data_out,  32'hDEADBEEF);
    check("compl_req_low",    req_out,   1'b0);

    // ---------------- back pressure ----------------
    src_valid = 1'b1;
    src_data  = 32'h11111111;
    tick();                                    // accept
    done_cnt = 0;
    bad_hold = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      if (data_out !== 32'h11111111) bad_hold++;
      if (done) begin
        done_cnt++;
        src_valid = 1'b0;
        ack_in    = 1'b0;
      end
      src_data = 32'hA0000000 + 32'(i);
      if (i == 2) ack_in = 1'b1;
      tick();
    end
    check("bp_finished",    busy,     1'b0);
    check("bp_done_count",  32'(done_cnt), 32'd1);
    check("bp_data_stable", 32'(bad_hold), 32'd0);
    check("bp_data_final",  data_out, 32'h11111111);
    $display("xfer backpressure data=0x%08h dones=%0d", data_out, done_cnt);
    src_valid = 1'b0;

    // ---------------- stale ack out of reset ----------------
    async_rst = 1'b1;
    ack_in    = 1'b1;
    tick();
    tick();
    async_rst = 1'b0;
    tick();
    tick();
    tick();                                    // ack_s now high
    src_valid = 1'b1;
    src_data  = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      check("stale_ready_low", src_ready, 1'b0);
      tick();
      check("stale_no_req",    req_out,   1'b0);
    end
    ack_in = 1'b0;
    tick();
    tick();
    check("stale_ready_d2",  src_ready, 1'b0);
    check("stale_req_d2",    req_out,   1'b0);
    tick();                                    // 3rd edge after ack fell
    check("stale_ready_d3",  src_ready, 1'b1);
    check("stale_req_d3",    req_out,   1'b0);
    tick();                                    // accept
    src_valid = 1'b0;
    check("stale_accept_req",  req_out,  1'b1);
    check("stale_accept_data", data_out, 32'hCAFEF00D);
    $display("xfer stale-ack data=0x%08h", data_out);

    // ---------------- reset mid-handshake ----------------
    tick();
    tick();
    ack_in = 1'b1;
    tick();
    #3 async_rst = 1'b1;
    sync_m = '0;
    #1;
    check("midrst_req",  req_out,  1'b0);
    check("midrst_data", data_out, 32'h0);
    check("midrst_busy", busy,     1'b0);
    check("midrst_done", done,     1'b0);
    @(posedge clk);
    #1;
    ack_in = 1'b0;
    tick();
    async_rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_idle",    busy,          1'b0);
    $display("xfer reset-abort dones=%0d", done_cnt);

    // ---------------- back-to-back stream with random ack delay ----------------
    sent      = 0;
    rcvd      = 0;
    viol      = 0;
    resp_wait = 0;
    src_valid = 1'b1;
    src_data  = 32'd1;
    for (int cyc = 0; cyc < 800 && rcvd < 8; cyc++) begin
      acc      = src_valid && src_ready;
      req_prev = req_out;
      tick();
      if (req_out && !req_prev && ack_s_pre) viol++;
      if (acc) begin
        sent++;
        if (sent < 8) src_data = 32'(sent + 1);
        else          src_valid = 1'b0;
      end
      if (done) begin
        rcvd++;
        check("stream_word", data_out, 32'(rcvd));
        $display("xfer stream %0d data=0x%08h", rcvd, data_out);
      end
      // destination responder with random latency in both phases
      if (req_out && !req_prev) resp_wait = $urandom_range(0, 5);
      if (resp_wait > 0) begin
        resp_wait--;
      end else if (req_out && !ack_in) begin
        ack_in    = 1'b1;
        resp_wait = $urandom_range(0, 4);
      end else if (!req_out && ack_in) begin
        ack_in    = 1'b0;
      end
    end
    check("stream_received",  32'(rcvd), 32'd8);
    check("stream_sent",      32'(sent), 32'd8);
    check("stream_stale_req", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_src.md
CDC_HANDSHAKE_SRC -- requirements
Module: cdc_handshake_src

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32: width of the transferred data word.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 3, legal range 2..4: number of flops in the ack synchronizer chain.
REQ-003 The module SHALL have port clk, input, 1 bit: single source-domain clock; all flops on its rising edge.
REQ-004 The module SHALL have port async_rst, input, 1 bit: asynchronous reset, active-high.
REQ-005 The module SHALL have port scan_enable, input, 1 bit: DFT hook with no functional effect.
REQ-006 The module SHALL have port src_valid, input, 1 bit: source offers src_data.
REQ-007 The module SHALL have port src_data, input, DATA_W bits: word to transfer.
REQ-008 The module SHALL have port src_ready, output, 1 bit: module can accept a word this cycle.
REQ-009 The module SHALL have port req_out, output, 1 bit: 4-phase request to the destination domain, driven directly from a flop.
REQ-010 The module SHALL have port data_out, output, DATA_W bits: held word to the destination domain, driven directly from flops.
REQ-011 The module SHALL have port ack_in, input, 1 bit: asynchronous acknowledge from the destination domain.
REQ-012 The module SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 The module SHALL have port done, output, 1 bit: one-cycle pulse when the destination acknowledges a word.

Function
REQ-014 ack_in SHALL pass through a SYNC_STAGES-flop chain; only the last flop (ack_s) SHALL be used by any logic.
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT_ACK_HI and WAIT_ACK_LO.
REQ-016 src_ready SHALL be high only when state is IDLE and ack_s is 0; it SHALL be combinational from registered signals only.
REQ-017 Accept SHALL occur on a rising edge with src_valid && src_ready. At that edge: data_out <= src_data, req_out <= 1, state <= WAIT_ACK_HI.
REQ-018 In WAIT_ACK_HI, on the edge that samples ack_s == 1: req_out <= 0, done <= 1 for exactly one cycle, state <= WAIT_ACK_LO.
REQ-019 In WAIT_ACK_LO, on the edge that samples ack_s == 0: state <= IDLE.
REQ-020 data_out SHALL change only on accept and SHALL hold its value from accept until the next accept, including through WAIT_ACK_LO and IDLE.
REQ-021 src_valid while src_ready is 0 SHALL be ignored; no word is captured or queued.
REQ-022 A stale ack_s == 1 in IDLE SHALL hold src_ready low until ack_s returns to 0; no request is issued meanwhile.
REQ-023 ack_in toggling in WAIT_ACK_LO before settling low SHALL only delay the return to IDLE; req_out SHALL stay 0.
REQ-024 Back-to-back transfers: src_ready SHALL go high in the cycle after the return to IDLE, provided ack_s is 0.

Reset
REQ-025 Asserting async_rst SHALL immediately force state = IDLE, req_out = 0, data_out = 0, done = 0, and all sync flops to 0; busy = 0 follows from state.
REQ-026 Reset asserted mid-handshake SHALL abandon the in-flight word without any done pulse.
REQ-027 After deassertion, src_ready SHALL go high once ack_s is 0.

Verification
REQ-028 Basic transfer: SYNC_STAGES = 3; accept 0xDEADBEEF at edge N; ack_in high just after N+2 -> req_out = 1 from N; done pulses at the 4th edge after ack rises; req_out falls at the same edge; data_out = 0xDEADBEEF throughout.
REQ-029 Handshake completion: ack_in dropped after req_out falls -> state returns to IDLE 4 edges later, and src_ready = 1 on the following cycle.
REQ-030 Back pressure: src_valid held high with changing src_data during WAIT_ACK_HI -> data_out stays unchanged and exactly one done pulse occurs per handshake.
REQ-031 Stale ack: ack_in = 1 out of reset -> src_ready = 0 and req_out = 0 until 3 edges after ack_in falls.
REQ-032 Reset mid-operation: async_rst pulsed in WAIT_ACK_HI -> req_out = 0 and data_out = 0 immediately, with no done pulse.
REQ-033 Back-to-back stream of 0x1..0x8 under randomized ack delay -> 8 done pulses in order, and req_out never rises while ack_s = 1.
